// File: rtl/data_mem_arbiter.sv
// Single-port data-memory arbiter: pipeline MEM stage vs. host loader, with read-data return routing.
// Optional host anti-starvation: define ARB_FAIR_EN to enable the MAX_WAIT wait counter.
module data_mem_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 24,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_stall,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, RD_P, RD_H} rd_state_t;

    rd_state_t         state_p1, state_nxt;
    logic              grant_p, grant_h;
    logic              host_due;
    logic [ADDR_W-1:0] addr_hold_p1;
    logic [DATA_W-1:0] wdata_hold_p1;
    logic [DATA_W-1:0] p_rdata_hold_p1, h_rdata_hold_p1;

`ifdef ARB_FAIR_EN
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    logic [CNT_W-1:0] wait_cnt_p1;

    assign host_due = h_req && (wait_cnt_p1 == CNT_W'(MAX_WAIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_p1 <= '0;
        end else if (grant_h) begin
            wait_cnt_p1 <= '0;
        end else if (h_req && (wait_cnt_p1 != CNT_W'(MAX_WAIT))) begin
            wait_cnt_p1 <= wait_cnt_p1 + 1'b1;
        end
    end
`else
    assign host_due = 1'b0;
`endif

    // Request cycle: grant and memory port drive are purely combinational
    always_comb begin
        grant_p = 1'b0;
        grant_h = 1'b0;
        if (rst) begin
            if (host_due) begin
                grant_h = 1'b1;
            end else if (p_req) begin
                grant_p = 1'b1;
            end else if (h_req) begin
                grant_h = 1'b1;
            end
        end
    end

    assign p_stall = p_req & ~grant_p;
    assign h_gnt   = grant_h;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = addr_hold_p1;
        mem_wdata = wdata_hold_p1;
        if (grant_p) begin
            mem_en    = 1'b1;
            mem_we    = p_we;
            mem_addr  = p_addr;
            mem_wdata = p_wdata;
        end else if (grant_h) begin
            mem_en    = 1'b1;
            mem_we    = h_we;
            mem_addr  = h_addr;
            mem_wdata = h_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_hold_p1  <= '0;
            wdata_hold_p1 <= '0;
        end else if (mem_en) begin
            addr_hold_p1  <= mem_addr;
            wdata_hold_p1 <= mem_wdata;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        if (grant_p && !p_we) begin
            state_nxt = RD_P;
        end else if (grant_h && !h_we) begin
            state_nxt = RD_H;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_p1 <= IDLE;
        end else begin
            state_p1 <= state_nxt;
        end
    end

    // Response cycle: read data is routed to whichever port issued last cycle's read
    assign p_rvalid = (state_p1 == RD_P);
    assign h_rvalid = (state_p1 == RD_H);
    assign p_rdata  = p_rvalid ? mem_rdata : p_rdata_hold_p1;
    assign h_rdata  = h_rvalid ? mem_rdata : h_rdata_hold_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_rdata_hold_p1 <= '0;
            h_rdata_hold_p1 <= '0;
        end else begin
            if (p_rvalid) p_rdata_hold_p1 <= mem_rdata;
            if (h_rvalid) h_rdata_hold_p1 <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard testbench for data_mem_arbiter: directed stimulus pushes expected read data,
// a negedge monitor pops and compares on every rvalid.
module tb_data_mem_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 24;

    logic              clk = 1'b0;
    logic              rst;
    logic              p_req, p_we, h_req, h_we;
    logic [ADDR_W-1:0] p_addr, h_addr;
    logic [DATA_W-1:0] p_wdata, h_wdata;
    logic              p_stall, p_rvalid, h_gnt, h_rvalid;
    logic [DATA_W-1:0] p_rdata, h_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] pq[$];
    logic [DATA_W-1:0] hq[$];

    always #5 clk = ~clk;

    data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_stall(p_stall), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous single-port memory
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every rvalid must match the oldest outstanding expectation on that port
    always @(negedge clk) begin
        if (rst) begin
            if (p_rvalid) begin
                if (pq.size() == 0) chk("p_rvalid_unexpected", 32'(p_rvalid), 32'd0);
                else chk("p_rdata", 32'(p_rdata), 32'(pq.pop_front()));
            end
            if (h_rvalid) begin
                if (hq.size() == 0) chk("h_rvalid_unexpected", 32'(h_rvalid), 32'd0);
                else chk("h_rdata", 32'(h_rdata), 32'(hq.pop_front()));
            end
        end
    end

    task automatic set_req(input logic pr, input logic pw, input logic [ADDR_W-1:0] pa,
                           input logic [DATA_W-1:0] pd, input logic hr, input logic hw,
                           input logic [ADDR_W-1:0] ha, input logic [DATA_W-1:0] hd);
        p_req = pr; p_we = pw; p_addr = pa; p_wdata = pd;
        h_req = hr; h_we = hw; h_addr = ha; h_wdata = hd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) mem[i] = '0;
        mem[14'h0010] = 24'h00ABCD;
        mem[14'h0001] = 24'h111111;
        mem[14'h0002] = 24'h222222;
        mem_rdata = '0;

        // Reset with both requesters active
        rst = 1'b0;
        set_req(1'b1, 1'b0, 14'h0005, 24'h0, 1'b1, 1'b0, 14'h0006, 24'h0);
        @(negedge clk); @(negedge clk);
        chk("rst_mem_en",   32'(mem_en),   32'd0);
        chk("rst_mem_we",   32'(mem_we),   32'd0);
        chk("rst_h_gnt",    32'(h_gnt),    32'd0);
        chk("rst_p_stall",  32'(p_stall),  32'd1);
        chk("rst_p_rvalid", 32'(p_rvalid), 32'd0);
        chk("rst_h_rvalid", 32'(h_rvalid), 32'd0);
        chk("rst_p_rdata",  32'(p_rdata),  32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        next_cycle();
        rst = 1'b1;
        set_req(1'b0, 1'b0, 14'h0, 24'h0, 1'b0, 1'b0, 14'h0, 24'h0);
        @(negedge clk);
        chk("idle_mem_en", 32'(mem_en), 32'd0);
        next_cycle();

        // Pipeline load from 0x0010
        set_req(1'b1, 1'b0, 14'h0010, 24'h0, 1'b0, 1'b0, 14'h0, 24'h0);
        pq.push_back(24'h00ABCD);
        @(negedge clk);
        chk("pload_mem_en",  32'(mem_en),   32'd1);
        chk("pload_p_stall", 32'(p_stall),  32'd0);
        chk("pload_addr",    32'(mem_addr), 32'h0010);
        next_cycle();
        set_req(1'b0, 1'b0, 14'h0, 24'h0, 1'b0, 1'b0, 14'h0, 24'h0);
        @(negedge clk);
        chk("pload_rvalid", 32'(p_rvalid), 32'd1);
        chk("pload_h_rvalid", 32'(h_rvalid), 32'd0);
        chk("idle_addr_hold", 32'(mem_addr), 32'h0010);
        next_cycle();

        // Host store then read at top address
        set_req(1'b0, 1'b0, 14'h0, 24'h0, 1'b1, 1'b1, 14'h3FFF, 24'hFFFFFF);
        @(negedge clk);
        chk("hst_h_gnt",  32'(h_gnt),  32'd1);
        chk("hst_mem_we", 32'(mem_we), 32'd1);
        next_cycle();
        set_req(1'b0, 1'b0, 14'h0, 24'h0, 1'b1, 1'b0, 14'h3FFF, 24'h0);
        hq.push_back(24'hFFFFFF);
        @(negedge clk);
        chk("hrd_h_gnt",  32'(h_gnt),  32'd1);
        chk("hrd_mem_we", 32'(mem_we), 32'd0);
        next_cycle();
        set_req(1'b0, 1'b0, 14'h0, 24'h0, 1'b0, 1'b0, 14'h0, 24'h0);
        @(negedge clk);
        chk("hrd_h_rvalid", 32'(h_rvalid), 32'd1);
        next_cycle();

        // Contention: pipeline stores vs. host reads of 0x0010
        set_req(1'b1, 1'b1, 14'h0020, 24'h123456, 1'b1, 1'b0, 14'h0010, 24'h0);
        for (int i = 1; i <= 15; i++) begin
`ifdef ARB_FAIR_EN
            if (i % 5 == 0) hq.push_back(24'h00ABCD);
            @(negedge clk);
            chk("cont_h_gnt",   32'(h_gnt),   (i % 5 == 0) ? 32'd1 : 32'd0);
            chk("cont_p_stall", 32'(p_stall), (i % 5 == 0) ? 32'd1 : 32'd0);
`else
            @(negedge clk);
            chk("cont_h_gnt",   32'(h_gnt),   32'd0);
            chk("cont_p_stall", 32'(p_stall), 32'd0);
`endif
            next_cycle();
        end
        p_req = 1'b0;
        hq.push_back(24'h00ABCD);
        @(negedge clk);
        chk("cont_release_h_gnt", 32'(h_gnt), 32'd1);
        next_cycle();
        set_req(1'b0, 1'b0, 14'h0, 24'h0, 1'b0, 1'b0, 14'h0, 24'h0);
        next_cycle();

        // Back-to-back host read then pipeline read
        set_req(1'b0, 1'b0, 14'h0, 24'h0, 1'b1, 1'b0, 14'h0001, 24'h0);
        hq.push_back(24'h111111);
        next_cycle();
        set_req(1'b1, 1'b0, 14'h0002, 24'h0, 1'b0, 1'b0, 14'h0, 24'h0);
        pq.push_back(24'h222222);
        @(negedge clk);
        chk("b2b_h_rvalid", 32'(h_rvalid), 32'd1);
        chk("b2b_p_stall",  32'(p_stall),  32'd0);
        next_cycle();
        set_req(1'b0, 1'b0, 14'h0, 24'h0, 1'b0, 1'b0, 14'h0, 24'h0);
        @(negedge clk);
        chk("b2b_p_rvalid", 32'(p_rvalid), 32'd1);
        chk("b2b_h_rvalid_off", 32'(h_rvalid), 32'd0);
        next_cycle();

        // Same sequence with reset pulsed in the second cycle
        set_req(1'b0, 1'b0, 14'h0, 24'h0, 1'b1, 1'b0, 14'h0001, 24'h0);
        next_cycle();
        rst = 1'b0;
        set_req(1'b1, 1'b0, 14'h0002, 24'h0, 1'b0, 1'b0, 14'h0, 24'h0);
        @(negedge clk);
        chk("rstmid_h_rvalid", 32'(h_rvalid), 32'd0);
        chk("rstmid_p_rvalid", 32'(p_rvalid), 32'd0);
        chk("rstmid_mem_en",   32'(mem_en),   32'd0);
        chk("rstmid_p_stall",  32'(p_stall),  32'd1);
        next_cycle();
        rst = 1'b1;
        set_req(1'b0, 1'b0, 14'h0, 24'h0, 1'b0, 1'b0, 14'h0, 24'h0);
        @(negedge clk);
        chk("rstrel_h_rvalid", 32'(h_rvalid), 32'd0);
        chk("rstrel_p_rvalid", 32'(p_rvalid), 32'd0);
        chk("rstrel_h_rdata",  32'(h_rdata),  32'd0);
        next_cycle();
        next_cycle();

        chk("pq_drained", 32'(pq.size()), 32'd0);
        chk("hq_drained", 32'(hq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
